// File: rtl/user_proj_pwm_multi.sv
// Multi-channel PWM generator with a Wishbone register file, shared prescaled
// period counter (edge or center aligned) and shadowed period/duty updates.
module user_proj_pwm_multi #(
  parameter int CHANNELS = 15,
  parameter int WIDTH    = 16,
  parameter int PRE_W    = 8
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic [31:0]         wbs_dat_o,
  output logic                wbs_ack_o,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [CHANNELS-1:0] pwm_oeb,
  output logic                irq
);

  localparam logic [5:0] ADR_CTRL   = 6'd0;
  localparam logic [5:0] ADR_PERIOD = 6'd1;
  localparam logic [5:0] ADR_PRE    = 6'd2;
  localparam logic [5:0] ADR_CH_EN  = 6'd3;
  localparam logic [5:0] ADR_POL    = 6'd4;
  localparam logic [5:0] ADR_STATUS = 6'd5;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  logic                      ack_q;
  logic [31:0]               dat_q;
  logic [2:0]                ctrl_q;
  logic [WIDTH-1:0]          per_sh_q;
  logic [WIDTH-1:0]          per_act_q;
  logic [PRE_W-1:0]          pre_val_q;
  logic [CHANNELS-1:0]       ch_en_q;
  logic [CHANNELS-1:0]       pol_q;
  logic                      wrap_q;
  logic [PRE_W-1:0]          pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0]          cnt_q, cnt_d;
  logic                      dir_down_q, dir_down_d;
  logic                      wrap_evt;
  logic                      update;
  logic                      req, wr;
  logic [5:0]                widx;
  logic [31:0]               rdata;
  logic [CHANNELS*WIDTH-1:0] duty_sh_flat;
  logic                      en, center, tick, status_clr;
  logic                      unused_adr;

  assign en         = ctrl_q[0];
  assign center     = ctrl_q[1];
  assign req        = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wr         = req & wbs_we_i;
  assign widx       = wbs_adr_i[7:2];
  assign unused_adr = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};
  assign tick       = (pre_cnt_q >= pre_val_q);
  assign update     = ~en | wrap_evt;
  assign status_clr = wr & (widx == ADR_STATUS) & wbs_sel_i[0] & wbs_dat_i[0];

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign pwm_oeb   = '0;
  assign irq       = wrap_q & ctrl_q[2];

  // Counter next state; '>=' comparisons keep it bounded after a mode switch.
  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    cnt_d      = cnt_q;
    dir_down_d = dir_down_q;
    wrap_evt   = 1'b0;
    if (!en) begin
      pre_cnt_d  = '0;
      cnt_d      = '0;
      dir_down_d = 1'b0;
    end else begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
      if (tick) begin
        if (!center) begin
          dir_down_d = 1'b0;
          if (cnt_q >= per_act_q) begin
            cnt_d    = '0;
            wrap_evt = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (per_act_q == '0) begin
          cnt_d      = '0;
          dir_down_d = 1'b0;
          wrap_evt   = 1'b1;
        end else if (!dir_down_q) begin
          if (cnt_q >= per_act_q) begin
            cnt_d      = per_act_q - 1'b1;
            dir_down_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          if (cnt_q == '0) begin
            cnt_d      = WIDTH'(1);
            dir_down_d = 1'b0;
            wrap_evt   = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pre_cnt_q  <= '0;
      cnt_q      <= '0;
      dir_down_q <= 1'b0;
      per_act_q  <= '0;
      wrap_q     <= 1'b0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      cnt_q      <= cnt_d;
      dir_down_q <= dir_down_d;
      if (update) per_act_q <= per_sh_q;
      if (wrap_evt) wrap_q <= 1'b1;
      else if (status_clr) wrap_q <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ctrl_q    <= '0;
      per_sh_q  <= '0;
      pre_val_q <= '0;
      ch_en_q   <= '0;
      pol_q     <= '0;
    end else if (wr) begin
      case (widx)
        ADR_CTRL:   ctrl_q    <= 3'(byte_merge(32'(ctrl_q), wbs_dat_i, wbs_sel_i));
        ADR_PERIOD: per_sh_q  <= WIDTH'(byte_merge(32'(per_sh_q), wbs_dat_i, wbs_sel_i));
        ADR_PRE:    pre_val_q <= PRE_W'(byte_merge(32'(pre_val_q), wbs_dat_i, wbs_sel_i));
        ADR_CH_EN:  ch_en_q   <= CHANNELS'(byte_merge(32'(ch_en_q), wbs_dat_i, wbs_sel_i));
        ADR_POL:    pol_q     <= CHANNELS'(byte_merge(32'(pol_q), wbs_dat_i, wbs_sel_i));
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (widx)
      ADR_CTRL:   rdata = 32'(ctrl_q);
      ADR_PERIOD: rdata = 32'(per_sh_q);
      ADR_PRE:    rdata = 32'(pre_val_q);
      ADR_CH_EN:  rdata = 32'(ch_en_q);
      ADR_POL:    rdata = 32'(pol_q);
      ADR_STATUS: rdata = 32'(wrap_q);
      default: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (widx == 6'(8 + i)) rdata = 32'(duty_sh_flat[i*WIDTH +: WIDTH]);
        end
      end
    endcase
  end

  // Single-cycle ack; read data is only non-zero during the ack cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= req;
      dat_q <= (req && !wbs_we_i) ? rdata : '0;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0] duty_sh_q;
    logic [WIDTH-1:0] duty_act_q;
    logic             pwm_q;

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        duty_sh_q  <= '0;
        duty_act_q <= '0;
        pwm_q      <= 1'b0;
      end else begin
        if (wr && widx == 6'(8 + gi))
          duty_sh_q <= WIDTH'(byte_merge(32'(duty_sh_q), wbs_dat_i, wbs_sel_i));
        if (update) duty_act_q <= duty_sh_q;
        pwm_q <= (en & ch_en_q[gi] & (cnt_q < duty_act_q)) ^ pol_q[gi];
      end
    end

    assign duty_sh_flat[gi*WIDTH +: WIDTH] = duty_sh_q;
    assign pwm_out[gi] = pwm_q;
  end

endmodule

// File: tb/tb_user_proj_pwm_multi.sv
// Directed bench for user_proj_pwm_multi: bus access, edge/center waveforms,
// shadowed duty update, boundaries/polarity, interrupt and reset.
module tb_user_proj_pwm_multi;
  localparam int CH = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [31:0]   adr, dat_i;
  logic [31:0]   dat_o;
  logic          ack;
  logic [CH-1:0] pwm_out, pwm_oeb;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  user_proj_pwm_multi #(.CHANNELS(CH), .WIDTH(16), .PRE_W(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat_i),
    .wbs_dat_o(dat_o),
    .wbs_ack_o(ack),
    .pwm_out  (pwm_out),
    .pwm_oeb  (pwm_oeb),
    .irq      (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Called just after a clock edge; the request is accepted at the next edge.
  task automatic wb_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    logic got;
    got = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'(idx) << 2; dat_i = d; sel = s;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1'b1; break; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check($sformatf("wr_ack_w%0d", idx), {31'b0, got}, 32'd1);
  endtask

  task automatic wb_read(input int idx, output logic [31:0] d);
    logic got;
    got = 1'b0;
    d = 32'hDEAD_BEEF;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'(idx) << 2; sel = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1'b1; d = dat_o; break; end
    end
    cyc = 1'b0; stb = 1'b0;
    if (!got) d = 32'hDEAD_BEEF;
  endtask

  task automatic measure_high(input int n, output int h);
    h = 0;
    repeat (n) begin @(posedge clk); #1; h += int'(pwm_out[0]); end
  endtask

  task automatic next_rise(output int n);
    logic prev;
    prev = pwm_out[0];
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (!prev && pwm_out[0]) begin n = i; break; end
      prev = pwm_out[0];
    end
  endtask

  task automatic high_run(output int n);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (pwm_out[0]) n++;
      else break;
    end
  endtask

  task automatic wait_irq_rise(output int n);
    logic prev;
    prev = irq;
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (!prev && irq) begin n = i; break; end
      prev = irq;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [19:0] v;
    int          n, h;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_i = '0;
    cyc_wait(3);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_oeb", 32'(pwm_oeb), 32'd0);
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    rst = 1'b0;
    cyc_wait(1);

    // Bus: unmapped word, byte selects, width truncation, ack width
    wb_write(7, 32'hFFFF_FFFF, 4'hF);
    wb_read(7, rd);
    check("rd_word7", rd, 32'd0);
    cyc_wait(1);
    check("ack_one_cycle", {31'b0, ack}, 32'd0);
    wb_read(23, rd);
    check("rd_duty_beyond", rd, 32'd0);
    wb_write(1, 32'h0000_0109, 4'hF);
    wb_write(1, 32'hFFFF_FF22, 4'b0001);
    wb_read(1, rd);
    check("period_sel0", rd, 32'h0000_0122);
    wb_write(1, 32'hABCD_1234, 4'hF);
    wb_read(1, rd);
    check("period_trunc", rd, 32'h0000_1234);
    wb_write(0, 32'hFFFF_FFFE, 4'hF);
    wb_read(0, rd);
    check("ctrl_rd", rd, 32'h0000_0006);
    wb_write(0, 32'd0, 4'hF);

    // Edge mode: period 10, 3 high
    wb_write(1, 32'd9, 4'hF);
    wb_write(2, 32'd0, 4'hF);
    wb_write(8, 32'd3, 4'hF);
    wb_write(3, 32'd1, 4'hF);
    wb_write(4, 32'd0, 4'hF);
    wb_write(0, 32'd1, 4'hF);
    cyc_wait(20);
    measure_high(50, h);
    check("edge_high50", 32'(h), 32'd15);
    next_rise(n);
    next_rise(n);
    check("edge_period", 32'(n), 32'd10);
    high_run(n);
    check("edge_hrun", 32'(n), 32'd3);
    check("edge_ch1_idle", {31'b0, pwm_out[1]}, 32'd0);

    // Shadowed duty: current period stays 3 high, next is 7 high
    next_rise(n);
    wb_write(8, 32'd7, 4'hF);
    v = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      v = {v[18:0], pwm_out[0]};
    end
    check("shadow_pattern", 32'(v), 32'(20'b10000000111111100011));

    // Boundaries and polarity
    wb_write(8, 32'd0, 4'hF);
    cyc_wait(15);
    measure_high(30, h);
    check("duty0_low", 32'(h), 32'd0);
    wb_write(8, 32'd10, 4'hF);
    cyc_wait(15);
    measure_high(30, h);
    check("dutymax_high", 32'(h), 32'd30);
    wb_write(4, 32'd1, 4'hF);
    cyc_wait(2);
    measure_high(30, h);
    check("dutymax_inv", 32'(h), 32'd0);
    wb_write(8, 32'd0, 4'hF);
    cyc_wait(15);
    measure_high(30, h);
    check("duty0_inv", 32'(h), 32'd30);
    wb_write(3, 32'd0, 4'hF);
    wb_write(4, 32'd3, 4'hF);
    cyc_wait(2);
    check("chdis_pol1", 32'(pwm_out[1:0]), 32'd3);
    wb_write(4, 32'd0, 4'hF);
    cyc_wait(2);
    check("chdis_pol0", 32'(pwm_out[1:0]), 32'd0);

    // Center mode with prescale 1: 16-cycle period, 6 cycles high around cnt=0
    wb_write(0, 32'd0, 4'hF);
    wb_write(1, 32'd4, 4'hF);
    wb_write(2, 32'd1, 4'hF);
    wb_write(8, 32'd2, 4'hF);
    wb_write(3, 32'd1, 4'hF);
    wb_write(0, 32'd3, 4'hF);
    cyc_wait(40);
    measure_high(64, h);
    check("center_high64", 32'(h), 32'd24);
    next_rise(n);
    next_rise(n);
    check("center_period", 32'(n), 32'd16);
    high_run(n);
    check("center_hrun", 32'(n), 32'd6);

    // Interrupt and W1C
    wb_write(0, 32'd0, 4'hF);
    wb_write(1, 32'd9, 4'hF);
    wb_write(2, 32'd0, 4'hF);
    wb_write(0, 32'd4, 4'hF);
    wb_write(5, 32'd1, 4'hF);
    check("irq_idle", {31'b0, irq}, 32'd0);
    wb_read(5, rd);
    check("status_clr0", rd, 32'd0);
    wb_write(0, 32'd5, 4'hF);
    wait_irq_rise(n);
    check("irq_first_wrap", 32'(n), 32'd10);
    wb_read(5, rd);
    check("status_set", rd, 32'd1);
    wb_write(5, 32'd1, 4'hF);
    check("irq_cleared", {31'b0, irq}, 32'd0);
    wb_read(5, rd);
    check("status_w1c", rd, 32'd0);
    wait_irq_rise(n);
    check("irq_again", {31'b0, irq}, 32'd1);
    cyc_wait(9);
    wb_write(5, 32'd1, 4'hF);
    wb_read(5, rd);
    check("w1c_vs_wrap", rd, 32'd1);
    check("irq_held", {31'b0, irq}, 32'd1);
    wb_write(0, 32'd1, 4'hF);
    check("irq_masked", {31'b0, irq}, 32'd0);

    // Reset while running
    wb_write(8, 32'd10, 4'hF);
    cyc_wait(15);
    check("pre_rst_pwm", {31'b0, pwm_out[0]}, 32'd1);
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = '0;
    cyc_wait(1);
    check("mrst_pwm", 32'(pwm_out), 32'd0);
    check("mrst_ack", {31'b0, ack}, 32'd0);
    check("mrst_irq", {31'b0, irq}, 32'd0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    cyc_wait(1);
    for (int i = 0; i < 6; i++) begin
      wb_read(i, rd);
      check($sformatf("mrst_reg%0d", i), rd, 32'd0);
    end
    wb_read(8, rd);
    check("mrst_duty0", rd, 32'd0);
    cyc_wait(5);
    check("mrst_pwm_idle", 32'(pwm_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
